// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with runtime-loadable pattern/mask,
// selectable overlapping detection and a saturating match counter.
module seq_detector_param #(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(4'b1010),
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in,
  input  logic             overlap_en,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned       FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FillFull = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CntMax   = '1;

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [PAT_W-1:0]  mask_q, mask_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;   // FILLING while < FillFull, ARMED at FillFull
  logic              match_q, match_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sat_q, sat_d;

  logic [PAT_W-1:0]  hist_nxt;
  logic [FILL_W-1:0] fill_inc;
  logic              hit;

  // State register: all state returns to reset values asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q   <= PATTERN;
      mask_q  <= '1;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Next-state: history shift, fill tracking, hit detection and counter update.
  always_comb begin
    hist_nxt = {hist_q[PAT_W-2:0], in};
    fill_inc = (fill_q == FillFull) ? FillFull : fill_q + FILL_W'(1);
    hit      = in_valid && !cfg_load && (fill_inc == FillFull) &&
               (((hist_nxt ^ pat_q) & mask_q) == '0);

    pat_d   = pat_q;
    mask_d  = mask_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = hit;
    cnt_d   = cnt_q;
    sat_d   = sat_q;

    if (cfg_load) begin
      // Reconfiguration flushes history; a coincident serial bit is dropped.
      pat_d  = cfg_pattern;
      mask_d = cfg_mask;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = hist_nxt;
      fill_d = (hit && !overlap_en) ? '0 : fill_inc;
    end

    // Clear beats a coincident hit; the pulse itself is still emitted.
    if (cnt_clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (hit && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CntMax) begin
        sat_d = 1'b1;
      end
    end
  end

  // Outputs are driven straight from registers.
  always_comb begin
    match     = match_q;
    match_cnt = cnt_q;
    cnt_sat   = sat_q;
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_seq_detector_param;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 2;
  localparam logic [PAT_W-1:0] DefPat = 4'b1010;
  localparam int CntMaxI = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             din = 1'b0;
  logic             overlap_en = 1'b1;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [PAT_W-1:0] cfg_mask = '0;
  logic             cnt_clr = 1'b0;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [PAT_W-1:0] m_pat;
  logic [PAT_W-1:0] m_mask;
  logic             m_bits[$];   // oldest first, at most PAT_W entries
  int               m_fresh;     // bits available toward the next match
  logic             m_match;
  int               m_cnt;
  logic             m_sat;

  seq_detector_param #(
    .PAT_W  (PAT_W),
    .PATTERN(DefPat),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in         (din),
    .overlap_en (overlap_en),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_mask   (cfg_mask),
    .cnt_clr    (cnt_clr),
    .match      (match),
    .match_cnt  (match_cnt),
    .cnt_sat    (cnt_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pat   = DefPat;
    m_mask  = '1;
    m_bits.delete();
    m_fresh = 0;
    m_match = 1'b0;
    m_cnt   = 0;
    m_sat   = 1'b0;
  endfunction

  function automatic void model_step(input logic v, input logic b, input logic ovl,
                                     input logic ld, input logic [PAT_W-1:0] p,
                                     input logic [PAT_W-1:0] m, input logic clr);
    logic hit;
    hit = 1'b0;
    if (ld) begin
      m_pat  = p;
      m_mask = m;
      m_bits.delete();
      m_fresh = 0;
    end else if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      m_fresh++;
      if (m_fresh >= PAT_W) begin
        hit = 1'b1;
        // queue index k holds pattern bit PAT_W-1-k
        for (int k = 0; k < PAT_W; k++) begin
          if (m_mask[PAT_W-1-k] && (m_bits[k] != m_pat[PAT_W-1-k])) hit = 1'b0;
        end
        if (hit && !ovl) m_fresh = 0;
      end
    end
    m_match = hit;
    if (clr) begin
      m_cnt = 0;
      m_sat = 1'b0;
    end else if (hit) begin
      if (m_cnt < CntMaxI) m_cnt++;
      if (m_cnt == CntMaxI) m_sat = 1'b1;
    end
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_match"}, 32'(match), 32'(m_match));
    check({tag, "_cnt"}, 32'(match_cnt), 32'(m_cnt));
    check({tag, "_sat"}, 32'(cnt_sat), 32'(m_sat));
  endtask

  // One clock cycle of stimulus; entered and left at posedge + 1.
  task automatic step(input logic v, input logic b, input logic ovl,
                      input logic ld = 1'b0, input logic [PAT_W-1:0] p = '0,
                      input logic [PAT_W-1:0] m = '0, input logic clr = 1'b0);
    in_valid    = v;
    din         = b;
    overlap_en  = ovl;
    cfg_load    = ld;
    cfg_pattern = p;
    cfg_mask    = m;
    cnt_clr     = clr;
    @(posedge clk);
    model_step(v, b, ovl, ld, p, m, clr);
    #1;
    check_outputs("cyc");
    in_valid = 1'b0;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  // Asynchronous reset pulse asserted mid-cycle.
  task automatic do_reset(input int dly);
    #(dly);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    check_outputs("rst_held");
    reset = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input logic ovl);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], ovl);
  endtask

  initial begin
    model_reset();
    do_reset(2);

    // T1: overlapping, 101010 -> two matches
    send_bits(16'b101010, 6, 1'b1);
    check("t1_cnt", 32'(match_cnt), 32'd2);

    // T2: non-overlapping, 10101010 -> matches after bits 4 and 8
    do_reset(3);
    send_bits(16'b10101010, 8, 1'b0);
    check("t2_cnt", 32'(match_cnt), 32'd2);

    // T3: gap inside a partial match
    do_reset(2);
    send_bits(16'b101, 3, 1'b1);
    repeat (5) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("t3_match", 32'(match), 32'd1);
    step(1'b0, 1'b0, 1'b1);
    check("t3_pulse_end", 32'(match), 32'd0);

    // T4: reload mid-stream; the coincident bit would have completed 1010
    do_reset(4);
    send_bits(16'b101, 3, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'b1100, 4'b1101);
    check("t4_drop", 32'(match), 32'd0);
    send_bits(16'b1110, 4, 1'b0);
    check("t4_dc_hit", 32'(match), 32'd1);
    send_bits(16'b1100, 4, 1'b0);
    check("t4_hit2", 32'(match), 32'd1);
    check("t4_cnt", 32'(match_cnt), 32'd2);

    // T5: saturation, then clear coincident with a hit
    do_reset(2);
    send_bits(16'b1010101010, 10, 1'b1);
    check("t5_cnt_sat", 32'(match_cnt), 32'd3);
    check("t5_sat", 32'(cnt_sat), 32'd1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
    check("t5_clr_pulse", 32'(match), 32'd1);
    check("t5_clr_cnt", 32'(match_cnt), 32'd0);
    check("t5_clr_sat", 32'(cnt_sat), 32'd0);

    // T6: async reset drops a partial match
    do_reset(2);
    send_bits(16'b101, 3, 1'b1);
    do_reset(5);
    step(1'b1, 1'b0, 1'b1);
    check("t6_nomatch", 32'(match), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [PAT_W-1:0] p, m;
      logic ld, clr;
      if ($urandom_range(0, 399) == 0) do_reset($urandom_range(1, 7));
      ld  = ($urandom_range(0, 49) == 0);
      clr = ($urandom_range(0, 29) == 0);
      p   = PAT_W'($urandom);
      case ($urandom_range(0, 3))
        0:       m = '0;
        1:       m = PAT_W'($urandom);
        default: m = '1;
      endcase
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) != 0,
           ld, p, m, clr);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
